// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, opcodes
// and instruction field positions.
package busca_instrucao_pkg;

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2,
        PARADO  = 2'd3
    } estado_t;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_COPY   = 3'b001;
    localparam logic [2:0] OP_READ   = 3'b010;
    localparam logic [2:0] OP_WRITE  = 3'b011;
    localparam logic [2:0] OP_IFZERO = 3'b100;
    localparam logic [2:0] OP_JUMP   = 3'b101;
    localparam logic [2:0] OP_SET    = 3'b110;
    localparam logic [2:0] OP_STOP   = 3'b111;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 13;
    localparam int BV_MSB    = 12;
    localparam int BV_LSB    = 11;
    localparam int CAMPO_MSB = 10;
    localparam int CAMPO_LSB = 0;

endpackage

// File: rtl/busca_instrucao_contador_pc.sv
// Program counter: a redirect load beats the sequential increment.
module contador_pc #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          carga,
    input  logic [AW-1:0] valor,
    input  logic          incrementa,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc <= '0;
        else if (carga)
            pc <= valor;
        else if (incrementa)
            pc <= pc + {{(AW-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: PC, imem req/ack fetch, decoded fields with valid/ready.
// Optional accepted-instruction counter enabled by BUSCA_CONTADOR_EN.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clock,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_dado,
    output logic          instr_valida,
    input  logic          instr_pronta,
    output logic [2:0]    opcode,
    output logic [1:0]    BitVerificacao,
    output logic [10:0]   campo,
    output logic [AW-1:0] pc_atual,
    input  logic          desvio,
    input  logic [AW-1:0] alvo,
    output logic          parado
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [15:0]   instr_cont
`endif
);

    estado_t       estado, prox_estado;
    logic [AW-1:0] pc;
    logic [AW-1:0] alvo_pendente;
    logic          descarta;
    logic          carga_pc, inc_pc;
    logic [AW-1:0] valor_pc;
    logic          em_espera, em_entrega, ack_ok, captura, aceita;

    assign em_espera  = (estado == ESPERA);
    assign em_entrega = (estado == ENTREGA);
    assign ack_ok     = em_espera && imem_ack;
    assign captura    = ack_ok && !descarta && !desvio;
    assign aceita     = em_entrega && instr_pronta && !desvio;

    // A redirect in the ack cycle is the newest target, so it wins over a pending one.
    assign carga_pc = (ack_ok && (descarta || desvio)) || (em_entrega && desvio);
    assign valor_pc = desvio ? alvo : alvo_pendente;
    assign inc_pc   = captura;

    contador_pc #(.AW(AW)) u_pc (
        .clock      (clock),
        .reset      (reset),
        .carga      (carga_pc),
        .valor      (valor_pc),
        .incrementa (inc_pc),
        .pc         (pc)
    );

    // PC only moves on the ack cycle in ESPERA, so the address holds for the whole request.
    assign imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= INICIO;
        else
            estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIO:  prox_estado = ESPERA;
            ESPERA:  if (captura) prox_estado = ENTREGA;
            ENTREGA: begin
                if (desvio)
                    prox_estado = ESPERA;
                else if (instr_pronta)
                    prox_estado = (opcode == OP_STOP) ? PARADO : ESPERA;
            end
            PARADO:  prox_estado = PARADO;
            default: prox_estado = INICIO;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        instr_valida = 1'b0;
        parado       = 1'b0;
        case (estado)
            ESPERA:  imem_req     = 1'b1;
            ENTREGA: instr_valida = 1'b1;
            PARADO:  parado       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode         <= '0;
            BitVerificacao <= '0;
            campo          <= '0;
            pc_atual       <= '0;
            descarta       <= 1'b0;
            alvo_pendente  <= '0;
        end else begin
            if (captura) begin
                opcode         <= imem_dado[OPC_MSB:OPC_LSB];
                BitVerificacao <= imem_dado[BV_MSB:BV_LSB];
                campo          <= imem_dado[CAMPO_MSB:CAMPO_LSB];
                pc_atual       <= pc;
            end
            if (ack_ok)
                descarta <= 1'b0;
            else if (em_espera && desvio) begin
                descarta      <= 1'b1;
                alvo_pendente <= alvo;
            end
        end
    end

`ifdef BUSCA_CONTADOR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            instr_cont <= '0;
        else if (aceita)
            instr_cont <= instr_cont + 16'd1;
    end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: fetch, stall, redirects, PC wrap, STOP and reset.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_dado;
    logic        instr_valida;
    logic        instr_pronta;
    logic [2:0]  opcode;
    logic [1:0]  BitVerificacao;
    logic [10:0] campo;
    logic [7:0]  pc_atual;
    logic        desvio;
    logic [7:0]  alvo;
    logic        parado;
`ifdef BUSCA_CONTADOR_EN
    logic [15:0] instr_cont;
`endif

    logic [15:0] mem [256];
    logic        ack_en;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    // Zero-wait memory whenever ack_en is set.
    assign imem_ack  = imem_req && ack_en;
    assign imem_dado = mem[imem_addr];

    busca_instrucao #(.AW(8), .IW(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_dado      (imem_dado),
        .instr_valida   (instr_valida),
        .instr_pronta   (instr_pronta),
        .opcode         (opcode),
        .BitVerificacao (BitVerificacao),
        .campo          (campo),
        .pc_atual       (pc_atual),
        .desvio         (desvio),
        .alvo           (alvo),
        .parado         (parado)
`ifdef BUSCA_CONTADOR_EN
        ,
        .instr_cont     (instr_cont)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cont(input string tag, input logic [15:0] exp);
`ifdef BUSCA_CONTADOR_EN
        chk(tag, {16'h0, instr_cont}, {16'h0, exp});
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'hA005;
        mem[8'h01] = 16'h4444;
        mem[8'h40] = 16'h2123;
        mem[8'hFF] = 16'h0001;
        reset = 1'b1; ack_en = 1'b1; instr_pronta = 1'b0; desvio = 1'b0; alvo = 8'h00;

        ciclo(); ciclo();
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_valida", {31'h0, instr_valida}, 32'h0);
        chk("rst_parado", {31'h0, parado}, 32'h0);
        chk("rst_opcode", {29'h0, opcode}, 32'h0);
        chk("rst_pc",     {24'h0, pc_atual}, 32'h0);
        chk_cont("rst_cont", 16'd0);

        // INICIO lasts one cycle with no request even though ack is enabled
        @(negedge clock); reset = 1'b0;
        chk("inicio_req", {31'h0, imem_req}, 32'h0);
        ciclo();
        chk("espera_req",  {31'h0, imem_req}, 32'h1);
        chk("espera_addr", {24'h0, imem_addr}, 32'h0);
        ciclo();
        chk("f0_valida", {31'h0, instr_valida}, 32'h1);
        chk("f0_opcode", {29'h0, opcode}, 32'h5);
        chk("f0_bv",     {30'h0, BitVerificacao}, 32'h0);
        chk("f0_campo",  {21'h0, campo}, 32'h005);
        chk("f0_pcat",   {24'h0, pc_atual}, 32'h0);

        // Stall in ENTREGA for 5 cycles
        for (int i = 0; i < 5; i++) begin
            ciclo();
            chk("stall_valida", {31'h0, instr_valida}, 32'h1);
            chk("stall_campo",  {21'h0, campo}, 32'h005);
            chk("stall_req",    {31'h0, imem_req}, 32'h0);
            chk("stall_pc",     {24'h0, imem_addr}, 32'h1);
        end
        instr_pronta = 1'b1; ack_en = 1'b0;
        ciclo();
        instr_pronta = 1'b0;
        chk("f1_req",  {31'h0, imem_req}, 32'h1);
        chk("f1_addr", {24'h0, imem_addr}, 32'h1);
        chk_cont("cont_1", 16'd1);

        // Redirect while waiting, ack arrives 3 cycles later
        desvio = 1'b1; alvo = 8'h40;
        ciclo();
        desvio = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("pend_addr",   {24'h0, imem_addr}, 32'h1);
            chk("pend_req",    {31'h0, imem_req}, 32'h1);
            chk("pend_valida", {31'h0, instr_valida}, 32'h0);
            ciclo();
        end
        ack_en = 1'b1;
        ciclo();
        chk("disc_valida", {31'h0, instr_valida}, 32'h0);
        chk("disc_req",    {31'h0, imem_req}, 32'h1);
        chk("disc_addr",   {24'h0, imem_addr}, 32'h40);
        ciclo();
        chk("f40_valida", {31'h0, instr_valida}, 32'h1);
        chk("f40_opcode", {29'h0, opcode}, 32'h1);
        chk("f40_campo",  {21'h0, campo}, 32'h123);
        chk("f40_pcat",   {24'h0, pc_atual}, 32'h40);

        // Redirect together with ready: the instruction is not accepted
        instr_pronta = 1'b1; desvio = 1'b1; alvo = 8'hFF;
        ciclo();
        desvio = 1'b0;
        chk("red_valida", {31'h0, instr_valida}, 32'h0);
        chk("red_addr",   {24'h0, imem_addr}, 32'hFF);
        chk("red_req",    {31'h0, imem_req}, 32'h1);
        chk_cont("cont_red", 16'd1);
        ciclo();
        chk("fff_valida", {31'h0, instr_valida}, 32'h1);
        chk("fff_pcat",   {24'h0, pc_atual}, 32'hFF);
        chk("fff_opcode", {29'h0, opcode}, 32'h0);
        chk("fff_campo",  {21'h0, campo}, 32'h001);
        chk("wrap_pc",    {24'h0, imem_addr}, 32'h0);
        mem[8'h00] = 16'hE000;
        ciclo();
        chk("wrap_req",  {31'h0, imem_req}, 32'h1);
        chk("wrap_addr", {24'h0, imem_addr}, 32'h0);
        chk_cont("cont_2", 16'd2);
        ciclo();
        chk("stop_valida", {31'h0, instr_valida}, 32'h1);
        chk("stop_opcode", {29'h0, opcode}, 32'h7);
        ciclo();
        chk("par_parado", {31'h0, parado}, 32'h1);
        chk("par_req",    {31'h0, imem_req}, 32'h0);
        chk("par_valida", {31'h0, instr_valida}, 32'h0);
        chk_cont("cont_3", 16'd3);

        // Halted: redirects are ignored
        desvio = 1'b1; alvo = 8'h10;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            chk("par_desv_req",    {31'h0, imem_req}, 32'h0);
            chk("par_desv_parado", {31'h0, parado}, 32'h1);
        end
        desvio = 1'b0; instr_pronta = 1'b0;

        reset = 1'b1;
        #1;
        chk("rst2_parado", {31'h0, parado}, 32'h0);
        chk("rst2_req",    {31'h0, imem_req}, 32'h0);
        chk("rst2_addr",   {24'h0, imem_addr}, 32'h0);
        chk("rst2_pcat",   {24'h0, pc_atual}, 32'h0);
        chk("rst2_opcode", {29'h0, opcode}, 32'h0);
        chk("rst2_campo",  {21'h0, campo}, 32'h0);
        chk_cont("rst2_cont", 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage of the 8-bit multi-cycle processor. It holds the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents the decoded fields (`opcode`, `BitVerificacao`, `campo`) to the control unit with a valid/ready handshake. It accepts PC redirects (JUMP / taken IFZERO) from the execute side and halts permanently after delivering a STOP instruction.

## Interface
- `AW`, 8: PC and instruction-memory address width.
- `IW`, 16: instruction word width.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request; held high until `imem_ack`.
- `imem_addr` output AW: fetch address; stable while `imem_req`=1.
- `imem_ack` input 1: memory completes the request this cycle; only meaningful while `imem_req`=1.
- `imem_dado` input IW: instruction word; sampled when `imem_req`&&`imem_ack`.
- `instr_valida` output 1: decoded fields are valid.
- `instr_pronta` input 1: the control unit accepts the instruction when `instr_valida`&&`instr_pronta`.
- `opcode` output 3: instruction bits [15:13].
- `BitVerificacao` output 2: instruction bits [12:11].
- `campo` output 11: instruction bits [10:0] (registers and immediate).
- `pc_atual` output AW: address of the instruction on the outputs.
- `desvio` input 1: single-cycle redirect pulse (JUMP, or IFZERO with Zero=1).
- `alvo` input AW: redirect target; sampled when `desvio`=1.
- `parado` output 1: stage halted after STOP.
- `instr_cont` output 16: count of accepted instructions. Present only with `BUSCA_CONTADOR_EN`.

## Operation
- States: INICIO, ESPERA, ENTREGA, PARADO. Reset enters INICIO.
- Reset values: PC=0, `imem_req`=0, `imem_addr`=0, `instr_valida`=0, `opcode`/`BitVerificacao`/`campo`=0, `pc_atual`=0, `parado`=0, `instr_cont`=0, discard flag=0.
- INICIO: `imem_req`=0. Moves to ESPERA unconditionally.
- ESPERA: `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack` with discard flag=0 and `desvio`=0: capture the word and `pc_atual`<=PC, then PC<=PC+1 mod 2^AW (255→0 wraps) and go to ENTREGA.
  - On `imem_ack` with discard flag=1: drop the word, PC<=pending target, clear the flag, stay in ESPERA (a new request starts the next cycle).
  - On `imem_ack` with `desvio`=1 in the same cycle: drop the word, PC<=`alvo`, stay in ESPERA.
  - On `desvio` without `imem_ack`: store `alvo` as the pending target and set the discard flag. `imem_addr` stays unchanged until the ack arrives. A later `desvio` overwrites the pending target.
- ENTREGA: `instr_valida`=1 and the fields are held stable. `imem_req`=0.
  - `desvio` takes priority over `instr_pronta`: drop the instruction, PC<=`alvo`, go to ESPERA. `instr_valida` falls the next cycle.
  - Otherwise, on `instr_pronta`: if `opcode`==3'b111 (STOP), go to PARADO; else go to ESPERA.
- PARADO: `parado`=1, `imem_req`=0, `instr_valida`=0. `desvio` is ignored. Only `reset` exits this state.
- A reset mid-transaction aborts immediately; an ack that arrives while INICIO is active is ignored.

## Timing
- Fetch latency: `instr_valida` rises in the cycle after the `imem_ack` cycle.
- Peak throughput: one instruction per 2 cycles (zero-wait memory, `instr_pronta` tied high).
- `imem_req`, `instr_valida` and `parado` are decoded from registered state only; there is no combinational path from any input to them.
- Redirect penalty: the first request to `alvo` is issued in the cycle after `desvio` (or after the pending ack).

## Configuration
- `BUSCA_CONTADOR_EN` defined: the `instr_cont` port and a 16-bit counter exist. The counter increments on each accepted instruction (`instr_valida`&&`instr_pronta`&&!`desvio`), including STOP, and wraps 65535→0. It resets to 0.
- `BUSCA_CONTADOR_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding (INICIO, ESPERA, ENTREGA, PARADO);
  - the opcode constants (ADD=000, COPY=001, READ=010, WRITE=011, IFZERO=100, JUMP=101, SET=110, STOP=111);
  - the field bit positions.
- Sub-module `contador_pc`: PC register with load (redirect) and increment, parameterised by AW. Everything else stays in `busca_instrucao`.

## Test plan
- Reset, then zero-wait memory returning 16'hA005 at address 0 with `instr_pronta`=1 -> `imem_req` low in INICIO; `opcode`=3'b101, `BitVerificacao`=2'b00, `campo`=11'h005, `pc_atual`=0; next request at `imem_addr`=1.
- `instr_pronta` held low for 5 cycles in ENTREGA -> `instr_valida` and the fields stay stable; no `imem_req`; PC=1.
- `desvio`=1 with `alvo`=8'h40 in ESPERA, with ack 3 cycles later -> `imem_addr` unchanged until the ack; word discarded; next request at 8'h40; `instr_valida` never asserts for the discarded word.
- `desvio` in the same cycle as `instr_pronta` in ENTREGA -> instruction not counted; next fetch from `alvo`.
- Fetch at PC=8'hFF -> next `imem_addr`=8'h00.
- STOP (16'hE000) accepted -> `parado`=1 the next cycle; no further `imem_req` despite `desvio`; `instr_cont` (with `BUSCA_CONTADOR_EN`) equals the number of accepted instructions including the STOP; asserting `reset` clears everything.
